// File: rtl/piso_shift_tx_pkg.sv
// rtl/piso_shift_tx_pkg.sv - shared state encoding and counter width helper for piso_shift_tx
package piso_shift_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   // Bit counter width; one bit minimum so WIDTH=2 still gets a real register.
   function automatic int cnt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// rtl/piso_shift_tx_if.sv - load handshake and serial output bundle for piso_shift_tx
interface piso_shift_tx_if #(
   parameter int WIDTH = 4
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             s_out;
   logic             s_valid;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data,
      input  load_ready, s_out, s_valid, busy, done
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, s_out, s_valid, busy, done
   );
endinterface

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - frame bit counter with sync zero, enable and last-bit flag
module piso_bit_cnt
   import piso_shift_tx_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = cnt_w(WIDTH)
) (
   input  logic clk,
   input  logic clear,
   input  logic i_zero,
   input  logic i_en,
   output logic o_last
);
   logic [CNT_W-1:0] r_count;

   // Index of the bit currently on the line; zeroing wins over counting.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_count <= '0;
      end else if (i_zero) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_last = (r_count == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - PISO transmitter top: FSM, shift register, parity stage under PISO_PARITY_BIT_EN
module piso_shift_tx
   import piso_shift_tx_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            clear,
   piso_shift_tx_if.slave  bus
);
   localparam int CNT_W = cnt_w(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             r_sout;
   logic             w_sout_nxt;
   logic             r_valid;
   logic             w_last;
   logic             w_ready;
   logic             w_done;
   logic             w_load;
   logic             w_cnt_zero;
   logic             w_cnt_en;
   logic             w_first_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_load_rest;
   logic [WIDTH-1:0] w_shift_adv;
`ifdef PISO_PARITY_BIT_EN
   logic             r_par;
   logic             w_par_nxt;
`endif

   // Bit ordering: the register always holds the not-yet-sent bits, next one at the exit end.
   assign w_first_bit = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
   assign w_load_rest = MSB_FIRST ? (bus.load_data << 1) : (bus.load_data >> 1);
   assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
   assign w_shift_adv = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

   piso_bit_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .clk    (clk),
      .clear  (clear),
      .i_zero (w_cnt_zero),
      .i_en   (w_cnt_en),
      .o_last (w_last)
   );

   // Next state, handshake, done pulse and next serial bit.
   always_comb begin
      w_next      = r_state;
      w_ready     = 1'b0;
      w_done      = 1'b0;
      w_load      = 1'b0;
      w_sout_nxt  = 1'b0;
      w_shift_nxt = '0;
`ifdef PISO_PARITY_BIT_EN
      w_par_nxt   = r_par;
`endif

      case (r_state)
         ST_IDLE:   w_ready = 1'b1;
         ST_SHIFT: begin
`ifndef PISO_PARITY_BIT_EN
            w_ready = w_last;
            w_done  = w_last;
`endif
         end
         ST_PARITY: begin
`ifdef PISO_PARITY_BIT_EN
            w_ready = 1'b1;
            w_done  = 1'b1;
`endif
         end
         default:   w_ready = 1'b0;
      endcase

      w_load = bus.load_valid && w_ready && !clear;

      case (r_state)
         ST_IDLE:   if (w_load) w_next = ST_SHIFT;
         ST_SHIFT: begin
            if (w_last) begin
`ifdef PISO_PARITY_BIT_EN
               w_next = ST_PARITY;
`else
               w_next = w_load ? ST_SHIFT : ST_IDLE;
`endif
            end
         end
         ST_PARITY: w_next = w_load ? ST_SHIFT : ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase

      if (w_load) begin
         w_sout_nxt  = w_first_bit;
         w_shift_nxt = w_load_rest;
`ifdef PISO_PARITY_BIT_EN
         w_par_nxt   = ^bus.load_data;
`endif
      end else if (w_next == ST_SHIFT) begin
         w_sout_nxt  = w_next_bit;
         w_shift_nxt = w_shift_adv;
`ifdef PISO_PARITY_BIT_EN
      end else if (w_next == ST_PARITY) begin
         w_sout_nxt  = r_par;
`endif
      end

      w_cnt_zero = w_load || (w_next != ST_SHIFT);
      w_cnt_en   = (r_state == ST_SHIFT);
   end

   // State and registered serial outputs; clear aborts any frame immediately.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_sout  <= 1'b0;
         r_valid <= 1'b0;
`ifdef PISO_PARITY_BIT_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_shift <= w_shift_nxt;
         r_sout  <= w_sout_nxt;
         r_valid <= (w_next != ST_IDLE);
`ifdef PISO_PARITY_BIT_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   assign bus.load_ready = w_ready && !clear;
   assign bus.s_out      = r_sout;
   assign bus.s_valid    = r_valid;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.done       = w_done;
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - scoreboard bench for piso_shift_tx (MSB-first and LSB-first instances)
module tb_piso_shift_tx;
   localparam int W = 4;
`ifdef PISO_PARITY_BIT_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic clear;
   always #5 clk = ~clk;

   piso_shift_tx_if #(.WIDTH(W)) bus_m ();
   piso_shift_tx_if #(.WIDTH(W)) bus_l ();

   piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .clear(clear), .bus(bus_m));
   piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .clear(clear), .bus(bus_l));

   typedef struct packed {logic v; logic d; logic dn; logic bsy; logic rdy;} samp_t;
   typedef struct packed {logic d; logic last;} exp_t;

   samp_t obs[$];
   exp_t  sb[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic push_frame(input logic [W-1:0] w, input bit msb);
      logic [W-1:0] wv;
      exp_t e;
      wv = w;
      for (int k = 0; k < W; k++) begin
         e.d    = wv[msb ? (W - 1 - k) : k];
         e.last = (k == W - 1) && !PAR;
         sb.push_back(e);
      end
      if (PAR) begin
         e.d    = ^wv;
         e.last = 1'b1;
         sb.push_back(e);
      end
   endtask

   function automatic samp_t sample(input bit sel);
      samp_t s;
      if (sel) s = '{v: bus_l.s_valid, d: bus_l.s_out, dn: bus_l.done, bsy: bus_l.busy, rdy: bus_l.load_ready};
      else     s = '{v: bus_m.s_valid, d: bus_m.s_out, dn: bus_m.done, bsy: bus_m.busy, rdy: bus_m.load_ready};
      return s;
   endfunction

   task automatic set_in(input bit sel, input logic v, input logic [W-1:0] d);
      if (sel) begin bus_l.load_valid = v; bus_l.load_data = d; end
      else     begin bus_m.load_valid = v; bus_m.load_data = d; end
   endtask

   // Offer up to two words, push expected bits on each accepted transfer, record ncyc samples.
   task automatic drive(input bit sel, input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input int nwords, input int ncyc);
      int          sent;
      logic        cur_v;
      logic [W-1:0] cur_d;
      logic        last_rdy;
      samp_t       s;
      obs.delete();
      sent = 0;
      @(negedge clk);
      cur_v = 1'b1; cur_d = w0;
      set_in(sel, cur_v, cur_d);
      s = sample(sel); last_rdy = s.rdy;
      repeat (ncyc) begin
         @(negedge clk);
         if (cur_v && last_rdy) begin
            push_frame(cur_d, !sel);
            sent++;
            if (sent < nwords) cur_d = w1;
            else begin cur_v = 1'b0; cur_d = ~cur_d; end
            set_in(sel, cur_v, cur_d);
         end
         s = sample(sel);
         obs.push_back(s);
         last_rdy = s.rdy;
      end
      set_in(sel, 1'b0, cur_d);
   endtask

   task automatic test_reset;
      samp_t s;
      clear = 1'b1;
      #3;
      s = sample(0);
      n_cmp++;
      if (s !== 5'b0) begin n_bad++; $display("FAIL reset_state: got v/d/done/busy/ready=%b want 00000", s); end
      #9 clear = 1'b0;
      #1 s = sample(0);
      n_cmp++;
      if (s.rdy !== 1'b1 || s.v !== 1'b0) begin n_bad++; $display("FAIL reset_release: got ready=%b s_valid=%b want 1 0", s.rdy, s.v); end
      drive(0, 4'b0111, 4'b0000, 1, 2);
      #1 clear = 1'b1;
      #2 s = sample(0);
      n_cmp++;
      if (s !== 5'b0) begin n_bad++; $display("FAIL clear_pulse: got v/d/done/busy/ready=%b want 00000", s); end
      #3 clear = 1'b0;
      #1 s = sample(0);
      n_cmp++;
      if (s.rdy !== 1'b1 || s.v !== 1'b0) begin n_bad++; $display("FAIL clear_pulse_release: got ready=%b s_valid=%b want 1 0", s.rdy, s.v); end
      sb.delete();
   endtask

   task automatic test_single;
      int fv, lv, nv;
      exp_t e;
      drive(0, 4'b1001, 4'b0000, 1, W + PAR + 2);
      fv = -1; lv = -1; nv = 0;
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i].v) begin
            if (fv < 0) fv = i;
            lv = i; nv++;
            if (sb.size() > 0) e = sb.pop_front(); else e = 2'bxx;
            if (obs[i].d !== e.d || obs[i].dn !== e.last || obs[i].rdy !== e.last || obs[i].bsy !== 1'b1) begin
               n_bad++; $display("FAIL single_bit%0d: got s_out=%b done=%b ready=%b busy=%b want %b %b %b 1", i, obs[i].d, obs[i].dn, obs[i].rdy, obs[i].bsy, e.d, e.last, e.last);
            end
         end else if (obs[i] !== 5'b00001) begin
            n_bad++; $display("FAIL single_idle%0d: got v/d/done/busy/ready=%b want 00001", i, obs[i]);
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_bad++; $display("FAIL single_missing: %0d bits not seen, want 0", sb.size()); end
      n_cmp++;
      if (nv != W + PAR || lv - fv + 1 != nv) begin n_bad++; $display("FAIL single_len: got %0d valid over span %0d want %0d contiguous", nv, lv - fv + 1, W + PAR); end
      sb.delete();
   endtask

   task automatic test_lsb_first;
      int fv, lv, nv;
      exp_t e;
      drive(1, 4'b1101, 4'b0000, 1, W + PAR + 2);
      fv = -1; lv = -1; nv = 0;
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i].v) begin
            if (fv < 0) fv = i;
            lv = i; nv++;
            if (sb.size() > 0) e = sb.pop_front(); else e = 2'bxx;
            if (obs[i].d !== e.d || obs[i].dn !== e.last || obs[i].rdy !== e.last) begin
               n_bad++; $display("FAIL lsb_bit%0d: got s_out=%b done=%b ready=%b want %b %b %b", i, obs[i].d, obs[i].dn, obs[i].rdy, e.d, e.last, e.last);
            end
         end else if (obs[i] !== 5'b00001) begin
            n_bad++; $display("FAIL lsb_idle%0d: got v/d/done/busy/ready=%b want 00001", i, obs[i]);
         end
      end
      n_cmp++;
      if (sb.size() != 0 || nv != W + PAR || lv - fv + 1 != nv) begin
         n_bad++; $display("FAIL lsb_frame: got %0d valid, %0d unseen want %0d and 0", nv, sb.size(), W + PAR);
      end
      sb.delete();
   endtask

   task automatic test_back_to_back;
      int fv, lv, nv;
      exp_t e;
      drive(0, 4'b1010, 4'b0110, 2, 2 * (W + PAR) + 2);
      fv = -1; lv = -1; nv = 0;
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i].v) begin
            if (fv < 0) fv = i;
            lv = i; nv++;
            if (sb.size() > 0) e = sb.pop_front(); else e = 2'bxx;
            if (obs[i].d !== e.d || obs[i].dn !== e.last || obs[i].rdy !== e.last || obs[i].bsy !== 1'b1) begin
               n_bad++; $display("FAIL b2b_bit%0d: got s_out=%b done=%b ready=%b busy=%b want %b %b %b 1", i, obs[i].d, obs[i].dn, obs[i].rdy, obs[i].bsy, e.d, e.last, e.last);
            end
         end else if (obs[i] !== 5'b00001) begin
            n_bad++; $display("FAIL b2b_idle%0d: got v/d/done/busy/ready=%b want 00001", i, obs[i]);
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_missing: %0d bits not seen, want 0", sb.size()); end
      n_cmp++;
      if (nv != 2 * (W + PAR) || lv - fv + 1 != nv) begin n_bad++; $display("FAIL b2b_gap: got %0d valid over span %0d want %0d contiguous", nv, lv - fv + 1, 2 * (W + PAR)); end
      sb.delete();
   endtask

   task automatic test_abort;
      exp_t  e;
      samp_t s;
      drive(0, 4'b1111, 4'b0000, 1, 3);
      for (int i = 0; i < 3; i++) begin
         e = sb.pop_front();
         n_cmp++;
         if (obs[i].v !== 1'b1 || obs[i].d !== e.d) begin n_bad++; $display("FAIL abort_pre%0d: got v=%b s_out=%b want 1 %b", i, obs[i].v, obs[i].d, e.d); end
      end
      #1 clear = 1'b1;
      #1 s = sample(0);
      n_cmp++;
      if (s.v !== 1'b0 || s.d !== 1'b0 || s.bsy !== 1'b0 || s.dn !== 1'b0) begin n_bad++; $display("FAIL abort_now: got v/d/done/busy=%b%b%b%b want 0000", s.v, s.d, s.dn, s.bsy); end
      #4 clear = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         s = sample(0);
         n_cmp++;
         if (s !== 5'b00001) begin n_bad++; $display("FAIL abort_after%0d: got v/d/done/busy/ready=%b want 00001", i, s); end
      end
      sb.delete();
   endtask

`ifdef PISO_PARITY_BIT_EN
   task automatic test_parity;
      int nv;
      exp_t e;
      drive(0, 4'b1011, 4'b1001, 2, 2 * (W + 1) + 2);
      n_cmp++;
      if (obs[4].v !== 1'b1 || obs[4].d !== 1'b1 || obs[4].dn !== 1'b1) begin n_bad++; $display("FAIL parity_1011: got v=%b s_out=%b done=%b want 1 1 1", obs[4].v, obs[4].d, obs[4].dn); end
      n_cmp++;
      if (obs[9].v !== 1'b1 || obs[9].d !== 1'b0 || obs[9].dn !== 1'b1) begin n_bad++; $display("FAIL parity_1001: got v=%b s_out=%b done=%b want 1 0 1", obs[9].v, obs[9].d, obs[9].dn); end
      nv = 0;
      foreach (obs[i]) begin
         if (obs[i].v) begin
            nv++;
            if (sb.size() > 0) e = sb.pop_front(); else e = 2'bxx;
            n_cmp++;
            if (obs[i].d !== e.d || obs[i].dn !== e.last || obs[i].rdy !== e.last) begin
               n_bad++; $display("FAIL parity_bit%0d: got s_out=%b done=%b ready=%b want %b %b %b", i, obs[i].d, obs[i].dn, obs[i].rdy, e.d, e.last, e.last);
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0 || nv != 10) begin n_bad++; $display("FAIL parity_frame: got %0d valid, %0d unseen want 10 and 0", nv, sb.size()); end
      sb.delete();
   endtask
`endif

   initial begin
      clear = 1'b1;
      set_in(0, 1'b0, '0);
      set_in(1, 1'b0, '0);
      test_reset;
      test_single;
      test_lsb_first;
      test_back_to_back;
      test_abort;
`ifdef PISO_PARITY_BIT_EN
      test_parity;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
